// File: rtl/axi_sram_slave.sv
// AXI3 slave that bridges single-outstanding read/write bursts onto a simple
// synchronous SRAM port (read data returns one cycle after the enable).
module axi_sram_slave #(
    parameter int RD_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        reset,
    // AR channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // R channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // AW channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // W channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // B channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    // SRAM port
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where valid and ready are both 1; valid never waits on ready.

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_q,  state_d;
    logic [3:0]  id_q,     id_d;
    logic [31:0] addr_q,   addr_d;
    logic [7:0]  len_q,    len_d;
    logic [2:0]  size_q,   size_d;
    logic [1:0]  burst_q,  burst_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q,  rlast_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q,  bresp_d;

    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic [31:0] addr_step;
    logic [31:0] addr_next;

    // The W channel id is not used by this slave.
    logic unused_wid;
    assign unused_wid = ^wid;

    // Losing channel is held off only when both request in the same cycle.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        if (!reset && state_q == S_IDLE) begin
            arready = (RD_PRIORITY != 0) ? 1'b1 : !awvalid;
            awready = (RD_PRIORITY != 0) ? !arvalid : 1'b1;
        end
    end

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready_q && !reset;

    // Sizes above a full word are clamped to 4 bytes per beat.
    always_comb begin
        addr_step = 32'd4;
        if (size_q == 3'd0) begin
            addr_step = 32'd1;
        end else if (size_q == 3'd1) begin
            addr_step = 32'd2;
        end
        addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + addr_step;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        bresp_d = bresp_q;

        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    size_d  = arsize;
                    burst_d = arburst;
                    cnt_d   = 8'd0;
                    state_d = S_RD_REQ;
                end else if (aw_hs) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = S_WR_DATA;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                rdata_d = sram_rdata;
                state_d = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (rready) begin
                    if (rlast_q) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_DATA: begin
                if (w_hs) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 8'd1;
                    if (wlast) begin
                        bresp_d = (!err_q && cnt_q == len_q) ? RESP_OKAY : RESP_SLVERR;
                        state_d = S_WR_RESP;
                    end else if (cnt_q == len_q) begin
                        // Every later beat overruns awlen; remember it for bresp.
                        err_d = 1'b1;
                    end
                end
            end
            S_WR_RESP: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rvalid_d = (state_d == S_RD_RESP);
        rlast_d  = (state_d == S_RD_RESP) && (cnt_d == len_d);
        wready_d = (state_d == S_WR_DATA);
        bvalid_d = (state_d == S_WR_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            id_q     <= 4'd0;
            addr_q   <= 32'd0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'd0;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            wready_q <= wready_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    assign rid    = id_q;
    assign rdata  = rdata_q;
    assign rresp  = RESP_OKAY;
    assign rlast  = rlast_q;
    assign rvalid = rvalid_q;
    assign wready = wready_q;
    assign bid    = id_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

    // Reset gates the enable so a burst cut short issues no further access.
    assign sram_en    = !reset && (state_q == S_RD_REQ || w_hs);
    assign sram_we    = w_hs ? wstrb : 4'b0000;
    assign sram_addr  = addr_q;
    assign sram_wdata = w_hs ? wdata : 32'd0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: drivers push expected SRAM accesses and
// R/B responses into queues; a negedge monitor pops and compares them.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [38:0] exp_r_q[$];
    logic [5:0]  exp_b_q[$];
    logic [67:0] exp_s_q[$];

    logic [31:0] sram_mem [logic [29:0]];
    logic [31:0] ref_mem  [logic [29:0]];

    logic        rready_rand = 1'b0;
    logic        bready_hold = 1'b0;
    int          r_hs_cnt = 0;
    time         last_rlast_time = 0;
    logic        stall_pending = 1'b0;
    logic [31:0] stall_data = 32'd0;
    logic [38:0] mon_r_exp;
    logic [5:0]  mon_b_exp;
    logic [67:0] mon_s_exp;
    logic [67:0] mon_s_got;
    logic [31:0] wb_data [0:7];
    logic [3:0]  wb_strb [0:7];

    axi_sram_slave #(.RD_PRIORITY(1)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        logic [31:0] step;
        step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        return (burst == 2'b00) ? a : a + step;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return 32'd0;
    endfunction

    // ---------------- SRAM model: read data one cycle after enable ----------------
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : 32'd0;
            end else begin
                sram_mem[sram_addr[31:2]] = merge(sram_mem.exists(sram_addr[31:2]) ?
                    sram_mem[sram_addr[31:2]] : 32'd0, sram_wdata, sram_we);
            end
        end
    end

    // ---------------- ready drivers ----------------
    initial begin
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rready = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bready = !bready_hold;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (sram_en) begin
            checks++;
            mon_s_got = {sram_we, sram_addr, (sram_we == 4'b0000) ? 32'd0 : sram_wdata};
            if (exp_s_q.size() == 0) begin
                errors++;
                $display("FAIL sram_unexpected: got we=%h addr=%h, required no access",
                         sram_we, sram_addr);
            end else begin
                mon_s_exp = exp_s_q.pop_front();
                if (mon_s_got !== mon_s_exp) begin
                    errors++;
                    $display("FAIL sram_access: got we/addr/wdata=%h, required %h",
                             mon_s_got, mon_s_exp);
                end
            end
        end

        if (!reset && stall_pending) begin
            checks++;
            if (!rvalid || rdata !== stall_data) begin
                errors++;
                $display("FAIL r_stall_stable: got rvalid=%0b rdata=%h, required 1 %h",
                         rvalid, rdata, stall_data);
            end
        end
        stall_pending = rvalid && !rready && !reset;
        stall_data    = rdata;

        if (rvalid && rready) begin
            checks++;
            r_hs_cnt++;
            if (rlast) last_rlast_time = $time;
            if (exp_r_q.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected: got rid/rdata/rresp/rlast=%h, required no beat",
                         {rid, rdata, rresp, rlast});
            end else begin
                mon_r_exp = exp_r_q.pop_front();
                if ({rid, rdata, rresp, rlast} !== mon_r_exp) begin
                    errors++;
                    $display("FAIL r_beat: got rid/rdata/rresp/rlast=%h, required %h",
                             {rid, rdata, rresp, rlast}, mon_r_exp);
                end
            end
        end

        if (bvalid && bready) begin
            checks++;
            if (exp_b_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got bid/bresp=%h, required no response", {bid, bresp});
            end else begin
                mon_b_exp = exp_b_q.pop_front();
                if ({bid, bresp} !== mon_b_exp) begin
                    errors++;
                    $display("FAIL b_resp: got bid/bresp=%h, required %h", {bid, bresp}, mon_b_exp);
                end
            end
        end
    end

    // ---------------- expectation helpers ----------------
    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        sram_mem[a[31:2]] = d;
        ref_mem[a[31:2]]  = d;
    endtask

    task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats);
        logic [31:0] a;
        a = addr;
        for (int b = 0; b < nbeats; b++) begin
            exp_s_q.push_back({4'b0000, a, 32'd0});
            exp_r_q.push_back({id, ref_rd(a), 2'b00, (b == int'(len))});
            a = next_addr(a, size, burst);
        end
    endtask

    task automatic push_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int nbeats);
        logic [31:0] a;
        a = addr;
        for (int b = 0; b < nbeats; b++) begin
            exp_s_q.push_back({wb_strb[b], a, wb_data[b]});
            ref_mem[a[31:2]] = merge(ref_rd(a), wb_data[b], wb_strb[b]);
            a = next_addr(a, size, burst);
        end
        exp_b_q.push_back({id, (nbeats == int'(len) + 1) ? 2'b00 : 2'b10});
    endtask

    // ---------------- drivers ----------------
    task automatic report_timeout(input bit got, input string name);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: ready stayed 0 for 300 cycles, required 1", name);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit got;
        got = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        report_timeout(got, "ar_timeout");
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit got;
        got = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (awready) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        report_timeout(got, "aw_timeout");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        bit got;
        got = 1'b0;
        wid = 4'hF; wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wready) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
        report_timeout(got, "w_timeout");
    endtask

    task automatic run_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input int nbeats);
        push_write(id, addr, len, 3'd2, 2'b01, nbeats);
        send_aw(id, addr, len, 3'd2, 2'b01);
        for (int b = 0; b < nbeats; b++) send_w(wb_data[b], wb_strb[b], b == nbeats - 1);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_s_q.size() == 0 && exp_r_q.size() == 0 && exp_b_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: pending sram=%0d r=%0d b=%0d, required 0 0 0",
                     exp_s_q.size(), exp_r_q.size(), exp_b_q.size());
            exp_s_q.delete(); exp_r_q.delete(); exp_b_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [54:0] v;
        v = {arready, awready, rvalid, bvalid, wready, sram_en, sram_we, rid, bid,
             rdata, rresp, bresp, rlast};
        checks++;
        if (v !== 55'd0) begin
            errors++;
            $display("FAIL %s: got outputs=%h, required 0", name, v);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit got;
        int base;
        reset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        sram_rdata = 32'd0;

        preload(32'h0000_0100, 32'hDEAD_BEEF);
        preload(32'h0000_0200, 32'h0A0B_0C00);
        preload(32'h0000_0204, 32'h0A0B_0C01);
        preload(32'h0000_0208, 32'h0A0B_0C02);
        preload(32'h0000_020C, 32'h0A0B_0C03);
        preload(32'h0000_0040, 32'hFFFF_FFFF);
        preload(32'h0000_0300, 32'h3333_0000);
        preload(32'h0000_0500, 32'h55AA_55AA);
        preload(32'h0000_0504, 32'h6677_8899);
        preload(32'hFFFF_FFFC, 32'hCAFE_F00D);
        preload(32'h0000_0000, 32'h0123_4567);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single read; expected beat written out by hand.
        exp_s_q.push_back({4'b0000, 32'h0000_0100, 32'd0});
        exp_r_q.push_back({4'h3, 32'hDEAD_BEEF, 2'b00, 1'b1});
        send_ar(4'h3, 32'h0000_0100, 8'd0, 3'd2, 2'b01);
        wait_done();

        // INCR burst with random rready back-pressure.
        rready_rand = 1'b1;
        push_read(4'h5, 32'h0000_0200, 8'd3, 3'd2, 2'b01, 4);
        send_ar(4'h5, 32'h0000_0200, 8'd3, 3'd2, 2'b01);
        wait_done();
        rready_rand = 1'b0;

        // Write with strobes, B held off by bready=0, then read back.
        wb_data[0] = 32'h1122_3344; wb_strb[0] = 4'b0011;
        wb_data[1] = 32'hAABB_CCDD; wb_strb[1] = 4'b1111;
        bready_hold = 1'b1;
        run_write(4'h6, 32'h0000_0040, 8'd1, 2);
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!(bvalid === 1'b1 && exp_b_q.size() == 1)) begin
            errors++;
            $display("FAIL b_stall_hold: got bvalid=%0b pending=%0d, required 1 1",
                     bvalid, exp_b_q.size());
        end
        bready_hold = 1'b0;
        wait_done();
        exp_s_q.push_back({4'b0000, 32'h0000_0040, 32'd0});
        exp_r_q.push_back({4'h1, 32'hFFFF_3344, 2'b00, 1'b0});
        exp_s_q.push_back({4'b0000, 32'h0000_0044, 32'd0});
        exp_r_q.push_back({4'h1, 32'hAABB_CCDD, 2'b00, 1'b1});
        send_ar(4'h1, 32'h0000_0040, 8'd1, 3'd2, 2'b01);
        wait_done();

        // Early wlast: awlen=3, only two beats -> SLVERR; next read is normal.
        wb_data[0] = 32'h0000_0080; wb_strb[0] = 4'b1111;
        wb_data[1] = 32'h0000_0084; wb_strb[1] = 4'b1111;
        run_write(4'h7, 32'h0000_0080, 8'd3, 2);
        wait_done();
        push_read(4'h2, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 1);
        send_ar(4'h2, 32'h0000_0100, 8'd0, 3'd2, 2'b01);
        wait_done();

        // Overrun: awlen=0 but two beats -> both written, SLVERR; read back 2nd word.
        wb_data[0] = 32'h9090_0001; wb_strb[0] = 4'b1111;
        wb_data[1] = 32'h9494_0002; wb_strb[1] = 4'b1100;
        run_write(4'h8, 32'h0000_0090, 8'd0, 2);
        wait_done();
        exp_s_q.push_back({4'b0000, 32'h0000_0094, 32'd0});
        exp_r_q.push_back({4'h4, 32'h9494_0000, 2'b00, 1'b1});
        send_ar(4'h4, 32'h0000_0094, 8'd0, 3'd2, 2'b01);
        wait_done();

        // Address wrap at 2^32, halfword stepping, oversize clamp.
        push_read(4'h9, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 2);
        send_ar(4'h9, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
        wait_done();
        push_read(4'hA, 32'h0000_0500, 8'd2, 3'd1, 2'b01, 3);
        send_ar(4'hA, 32'h0000_0500, 8'd2, 3'd1, 2'b01);
        wait_done();
        push_read(4'hB, 32'h0000_0500, 8'd1, 3'd5, 2'b10, 2);
        send_ar(4'hB, 32'h0000_0500, 8'd1, 3'd5, 2'b10);
        wait_done();

        // Simultaneous AR and AW: read first, AW taken right after rlast.
        push_read(4'hC, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 1);
        wb_data[0] = 32'h5555_AAAA; wb_strb[0] = 4'b1111;
        push_write(4'hD, 32'h0000_0060, 8'd0, 3'd2, 2'b01, 1);
        arid = 4'hC; araddr = 32'h0000_0100; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'hD; awaddr = 32'h0000_0060; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1;
        awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (!(arready === 1'b1 && awready === 1'b0)) begin
            errors++;
            $display("FAIL ar_aw_priority: got arready=%0b awready=%0b, required 1 0",
                     arready, awready);
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (awready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || ($time - last_rlast_time) != 10) begin
            errors++;
            $display("FAIL aw_after_rlast: got accepted=%0b gap=%0t, required 1 10",
                     got, $time - last_rlast_time);
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        send_w(wb_data[0], wb_strb[0], 1'b1);
        wait_done();

        // Reset after the 2nd beat of a 4-beat FIXED read.
        base = r_hs_cnt;
        push_read(4'hE, 32'h0000_0300, 8'd3, 3'd2, 2'b00, 2);
        send_ar(4'hE, 32'h0000_0300, 8'd3, 3'd2, 2'b00);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (r_hs_cnt - base >= 2) begin got = 1'b1; break; end
        end
        #1;
        reset = 1'b1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midburst_beats: got %0d beats, required 2", r_hs_cnt - base);
        end
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midburst_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL arready_after_reset: got %0b, required 1", arready);
        end
        @(posedge clk);
        #1;
        wait_done();

        // Recovery read after the abandoned burst.
        push_read(4'h0, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 1);
        send_ar(4'h0, 32'h0000_0000, 8'd0, 3'd2, 2'b01);
        wait_done();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 The block SHALL have parameter RD_PRIORITY, default 1, meaning that when set, AR wins over AW when both are valid in IDLE; when cleared, AW wins.
REQ-002 The block SHALL have the port clk, input, 1 bit: clock, all logic rising-edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high.
REQ-004 The block SHALL have AR channel ports: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-005 The block SHALL have R channel ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 The block SHALL have AW channel ports: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-007 The block SHALL have W channel ports: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 The block SHALL have B channel ports: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-009 The block SHALL have SRAM port signals, out unless noted:
- sram_en, 1 bit
- sram_we, 4 bits
- sram_addr, 32 bits
- sram_wdata, 32 bits
- sram_rdata, in, 32 bits, valid exactly one cycle after an sram_en read
REQ-010 The block SHALL ignore the AxLOCK, AxCACHE and AxPROT fields and SHALL NOT have ports for them.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA and WR_RESP, with exactly one transaction outstanding at any time.
REQ-012 In IDLE, arready SHALL be 1 and awready SHALL be 1, except that the losing channel's ready SHALL be 0 when arvalid and awvalid are both 1, per RD_PRIORITY; arready and awready SHALL be 0 in all other states.
REQ-013 An AR handshake SHALL latch id, addr, len, size and burst, SHALL clear the beat counter, and SHALL go to RD_REQ.
REQ-014 In RD_REQ the block SHALL assert sram_en=1, sram_we=0 and sram_addr=current address for one cycle, then go to RD_WAIT.
REQ-015 In RD_WAIT the block SHALL capture sram_rdata into the rdata register and go to RD_RESP.
REQ-016 In RD_RESP the block SHALL hold rvalid=1, rid=latched id and rresp=2'b00, with rlast=1 iff beat counter == len; rdata SHALL stay stable until rready.
REQ-017 On an R handshake with rlast=1 the block SHALL go to IDLE; otherwise it SHALL advance the address, increment the counter and go to RD_REQ, giving a minimum of 3 cycles per read beat.
REQ-018 A W beat SHALL be accepted only in WR_DATA, where wready=1.
REQ-019 On an AW handshake the block SHALL latch the AW fields, clear the beat counter and go to WR_DATA.
REQ-020 On each W handshake the block SHALL drive sram_en=1, sram_we=wstrb, sram_addr=current address and sram_wdata=wdata in that same cycle (combinational), then advance the address and the counter.
REQ-021 A W handshake with wlast=1 SHALL move the FSM to WR_RESP, with bresp=2'b00 if the accepted beat count == awlen+1 and 2'b10 (SLVERR) otherwise.
REQ-022 Beats beyond awlen+1 without wlast SHALL still be written, and the error SHALL be recorded.
REQ-023 In WR_RESP the block SHALL hold bvalid=1 with bid=latched awid until bready, then go to IDLE; wid SHALL be ignored.
REQ-024 Address advance SHALL follow the burst type:
- FIXED (2'b00): address unchanged
- INCR (2'b01), WRAP (2'b10) and reserved (2'b11): address += (1 << min(size,2)), 32-bit wrap-around modulo 2^32
- arsize/awsize > 2 SHALL be treated as 2
REQ-025 The beat counter SHALL be 8 bits wide, so arlen=255 SHALL yield 256 beats.
REQ-026 sram_en SHALL be 0 in every state and cycle not listed above.
REQ-027 rready and bready held 0 indefinitely SHALL stall the FSM without losing data.

Reset
REQ-028 While reset=1 the FSM SHALL be in IDLE, and rvalid, bvalid, wready and sram_en SHALL be 0, sram_we SHALL be 4'b0, and rid, bid, rdata, rresp, bresp and rlast SHALL be 0.
REQ-029 During reset, arready and awready SHALL be 0.
REQ-030 A reset asserted mid-burst SHALL abandon the transaction with no further SRAM access and no R or B response.

Verification
REQ-031 The bench SHALL cover a single read: araddr=0x100, arlen=0, arsize=2, INCR, with mem[0x100]=0xDEADBEEF -> one R beat, rdata=0xDEADBEEF, rlast=1, rresp=0, rid=arid.
REQ-032 The bench SHALL cover an INCR read burst: araddr=0x200, arlen=3, arsize=2 -> sram reads at 0x200, 0x204, 0x208 and 0x20C; rlast only on the 4th beat; rready toggled randomly with data stable while stalled.
REQ-033 The bench SHALL cover a write with strobes: awaddr=0x40, awlen=1, beats 0x11223344/wstrb=4'b0011 and 0xAABBCCDD/wstrb=4'b1111 with wlast on beat 2 -> sram_we 0011 at 0x40, then 1111 at 0x44; bresp=0, bid=awid.
REQ-034 The bench SHALL cover early wlast: awlen=3 with wlast on beat 2 -> 2 writes, then bresp=2'b10; a following read succeeds normally.
REQ-035 The bench SHALL cover simultaneous AR+AW in IDLE with RD_PRIORITY=1 -> the AR is accepted first and awready=0 that cycle; the AW is accepted in the first IDLE cycle after rlast.
REQ-036 The bench SHALL cover reset after the 2nd beat of a 4-beat FIXED read at 0x300 -> rvalid=0 the next cycle, no further sram_en, and arready=1 after reset is released.
